// File: rtl/dct_pkg.sv
// Shared types and elaboration-time helpers for the serial DCT engine:
// transform mode, FSM state codes, accumulator sizing and coefficient generation.
package dct_pkg;

    typedef enum logic {
        DCT_FWD = 1'b0,
        DCT_INV = 1'b1
    } dct_mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    function automatic int dct_acc_width(int in_w, int coeff_w, int n_pts);
        return in_w + coeff_w + $clog2(n_pts);
    endfunction

    // Entry C[k][n] of the orthonormal DCT-II matrix, rounded to nearest in Q1.frac_bits.
    // Integer-only (Q30 Taylor series) so it folds to a constant during elaboration.
    function automatic int dct_coeff(int n_pts, int k, int n, int frac_bits);
        longint pi_q30;
        longint sqrt2_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scale;
        longint prod;
        int     m;
        int     r;
        int     p;
        bit     neg;
        pi_q30    = 64'sd3373259426;
        sqrt2_q30 = 64'sd1518500250;
        m   = ((2 * n + 1) * k) % (4 * n_pts);
        neg = 1'b0;
        if (m <= n_pts) begin
            r = m;
        end else if (m <= 2 * n_pts) begin
            r   = 2 * n_pts - m;
            neg = 1'b1;
        end else if (m <= 3 * n_pts) begin
            r   = m - 2 * n_pts;
            neg = 1'b1;
        end else begin
            r = 4 * n_pts - m;
        end
        x    = (longint'(r) * pi_q30) / longint'(2 * n_pts);
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int i = 1; i <= 12; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        if (sum < 0) begin
            sum = 0;
        end
        // c(k)^2 is 2^-p; odd p needs the extra factor of sqrt(2)
        p = (k == 0) ? $clog2(n_pts) : $clog2(n_pts) - 1;
        if (p % 2 == 0) begin
            scale = (64'sd1 <<< 30) >>> (p / 2);
        end else begin
            scale = sqrt2_q30 >>> ((p + 1) / 2);
        end
        prod = sum * scale;
        prod = (prod + (64'sd1 <<< (59 - frac_bits))) >>> (60 - frac_bits);
        return neg ? -int'(prod) : int'(prod);
    endfunction

endpackage

// File: rtl/dct_serial_engine_if.sv
// Sample-in / coefficient-out streaming bus of the serial DCT engine.
// The engine connects through the slave modport, its driver through master.
interface dct_serial_engine_if #(
    parameter int N     = 8,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    localparam int IDX_W = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, busy
    );

endinterface

// File: rtl/dct_coeff_rom.sv
// Combinational DCT-II coefficient ROM addressed by {k, n}; contents are
// generated from dct_pkg::dct_coeff while the design elaborates.
module dct_coeff_rom
    import dct_pkg::*;
#(
    parameter int  N         = 8,
    parameter int  COEFF_W   = 16,
    parameter int  FRAC_BITS = 15,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic [2*IDX_W-1:0]        addr,
    output logic signed [COEFF_W-1:0] coeff
);

    logic signed [COEFF_W-1:0] rom [N*N];

    for (genvar k = 0; k < N; k++) begin : g_row
        for (genvar n = 0; n < N; n++) begin : g_col
            localparam int CVAL = dct_coeff(N, k, n, FRAC_BITS);
            assign rom[k*N+n] = COEFF_W'(CVAL);
        end
    end

    assign coeff = rom[addr];

endmodule

// File: rtl/dct_serial_engine.sv
// Serial N-point orthonormal DCT-II/DCT-III engine: buffered samples, one MAC per cycle.
// Define DCT_SAT_EN to clamp out-of-range results; otherwise they wrap to OUT_W bits.
module dct_serial_engine
    import dct_pkg::*;
#(
    parameter int N         = 8,
    parameter int IN_W      = 16,
    parameter int COEFF_W   = 16,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 15
) (
    input logic               clk,
    input logic               rst_n,
    dct_serial_engine_if.slave bus
);

    localparam int ACC_W  = dct_acc_width(IN_W, COEFF_W, N);
    localparam int IDX_W  = $clog2(N);
    localparam int CNT_W  = IDX_W + 1;
    localparam int PROD_W = IN_W + COEFF_W;
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) <<< (FRAC_BITS - 1);

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    dct_mode_e                mode_q, mode_d;
    logic signed [IN_W-1:0]   samp_q [N];
    logic signed [IN_W-1:0]   samp_d [N];
    logic signed [OUT_W-1:0]  out_q, out_d;

    logic [IDX_W-1:0]         n_idx;
    logic [2*IDX_W-1:0]       rom_addr;
    logic signed [COEFF_W-1:0] coeff;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  acc_out;

    // The inverse transform reuses the forward ROM with the address transposed.
    assign n_idx    = n_q[IDX_W-1:0];
    assign rom_addr = (mode_q == DCT_INV) ? {n_idx, k_q} : {k_q, n_idx};

    dct_coeff_rom #(
        .N         (N),
        .COEFF_W   (COEFF_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_rom (
        .addr  (rom_addr),
        .coeff (coeff)
    );

    assign prod     = PROD_W'(samp_q[n_idx]) * PROD_W'(coeff);
    assign prod_ext = ACC_W'(prod);

`ifdef DCT_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -(ACC_W'(1) <<< (OUT_W - 1));

    logic signed [ACC_W-1:0] acc_rnd;

    assign acc_rnd = (acc_q + RND_BIAS) >>> FRAC_BITS;

    always_comb begin
        if (acc_rnd > OUT_MAX) begin
            acc_out = OUT_MAX[OUT_W-1:0];
        end else if (acc_rnd < OUT_MIN) begin
            acc_out = OUT_MIN[OUT_W-1:0];
        end else begin
            acc_out = acc_rnd[OUT_W-1:0];
        end
    end
`else
    assign acc_out = OUT_W'((acc_q + RND_BIAS) >>> FRAC_BITS);
`endif

    // MAC runs one extra cycle (n == N) to register the rounded result.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        samp_d  = samp_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    samp_d[0] = bus.in_data;
                    mode_d    = dct_mode_e'(bus.in_mode);
                    n_d       = CNT_W'(1);
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    samp_d[n_idx] = bus.in_data;
                    if (n_q == CNT_W'(N - 1)) begin
                        n_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        n_d = n_q + CNT_W'(1);
                    end
                end
            end
            ST_MAC: begin
                if (n_q == CNT_W'(N)) begin
                    out_d   = acc_out;
                    state_d = ST_OUT;
                end else begin
                    acc_d = acc_q + prod_ext;
                    n_d   = n_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    n_d   = '0;
                    acc_d = '0;
                    if (k_q == IDX_W'(N - 1)) begin
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + IDX_W'(1);
                        state_d = ST_MAC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            mode_q  <= DCT_FWD;
            out_q   <= '0;
            for (int i = 0; i < N; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            samp_q  <= samp_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_q;
    assign bus.out_index = k_q;
    assign bus.out_last  = (state_q == ST_OUT) && (k_q == IDX_W'(N - 1));
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dct_serial_engine.sv
// Self-checking bench for dct_serial_engine (N=8): directed spec vectors, backpressure,
// mid-block reset and random blocks against a real-arithmetic DCT reference.
module tb_dct_serial_engine;
    import dct_pkg::*;

    localparam int  N         = 8;
    localparam int  IN_W      = 16;
    localparam int  COEFF_W   = 16;
    localparam int  OUT_W     = 16;
    localparam int  FRAC_BITS = 15;
    localparam real PI        = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   coef [N][N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dct_serial_engine_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct_serial_engine #(
        .N         (N),
        .IN_W      (IN_W),
        .COEFF_W   (COEFF_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(longint a, longint d);
        longint q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int fit_out(longint v);
        longint lim = longint'(1) <<< (OUT_W - 1);
`ifdef DCT_SAT_EN
        if (v > lim - 1) return int'(lim - 1);
        if (v < -lim) return int'(-lim);
        return int'(v);
`else
        longint m = (v + lim) % (2 * lim);
        if (m < 0) m = m + 2 * lim;
        return int'(m - lim);
`endif
    endfunction

    // Reference transform: y = C*x (forward) or y = C^T*x (inverse), then round and fit.
    task automatic ref_dct(input int x[N], input bit inv, output int y[N]);
        for (int k = 0; k < N; k++) begin
            longint acc = 0;
            for (int n = 0; n < N; n++) begin
                acc += longint'(inv ? coef[n][k] : coef[k][n]) * longint'(x[n]);
            end
            y[k] = fit_out(floor_div(acc + (longint'(1) <<< (FRAC_BITS - 1)),
                                     longint'(1) <<< FRAC_BITS));
        end
    endtask

    task automatic apply_stimulus(input int x[N], input bit mode, output int e_cyc);
        for (int i = 0; i < N; i++) begin
            int guard = 0;
            bit rdy = 1'b0;
            bit accepted = 1'b0;
            bus.in_data  = IN_W'(x[i]);
            bus.in_mode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            while (!accepted && guard < 50) begin
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                accepted = rdy;
                guard++;
            end
            check($sformatf("in_accept_wait[%0d]", i), guard, 1);
        end
        bus.in_valid = 1'b0;
        e_cyc = cyc;
    endtask

    // stall_mode: 0 none, 1 five stall cycles on output 2, 2 random 0..3 per output.
    task automatic check_output(input int y[N], input int e_cyc, input int stall_mode,
                                input bit junk);
        int h_cyc = e_cyc;
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IN_W'($urandom_range(0, 65535));
        end
        for (int k = 0; k < N; k++) begin
            int guard = 0;
            int ns = 0;
            while (bus.out_valid !== 1'b1 && guard < 4 * N + 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check($sformatf("out_valid_wait[%0d]", k), bus.out_valid, 1);
            check($sformatf("out_latency[%0d]", k), cyc - h_cyc, N + 1);
            check($sformatf("busy_out[%0d]", k), bus.busy, 1);
            check($sformatf("in_ready_out[%0d]", k), bus.in_ready, 0);
            if (stall_mode == 1 && k == 2) ns = 5;
            else if (stall_mode == 2) ns = int'($urandom_range(0, 3));
            for (int s = 0; s < ns; s++) begin
                @(posedge clk);
                #1;
                check($sformatf("stall_valid[%0d]", k), bus.out_valid, 1);
                check($sformatf("stall_data[%0d]", k), bus.out_data, y[k]);
                check($sformatf("stall_index[%0d]", k), bus.out_index, k);
            end
            check($sformatf("out_data[%0d]", k), bus.out_data, y[k]);
            check($sformatf("out_index[%0d]", k), bus.out_index, k);
            check($sformatf("out_last[%0d]", k), bus.out_last, (k == N - 1) ? 1 : 0);
            if (junk && k == N - 1) bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            h_cyc = cyc;
            if (k < N - 1) check($sformatf("out_valid_drop[%0d]", k), bus.out_valid, 0);
        end
        check("in_ready_after_block", bus.in_ready, 1);
        check("busy_after_block", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  x[N];
        int  y[N];
        int  e_cyc;
        int  amp;
        bit  mode;
        real c;
        real v;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < N; n++) begin
                c = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
                v = c * $cos(real'((2 * n + 1) * k) * PI / (2.0 * N)) * real'(1 << FRAC_BITS);
                coef[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);

        $display("[TB] forward DC block");
        for (int i = 0; i < N; i++) x[i] = 1000;
        y = '{2828, 0, 0, 0, 0, 0, 0, 0};
        apply_stimulus(x, 1'b0, e_cyc);
        check_output(y, e_cyc, 0, 1'b0);

        $display("[TB] forward impulse block with output backpressure");
        for (int i = 0; i < N; i++) x[i] = 0;
        x[0] = 1000;
        ref_dct(x, 1'b0, y);
        check("ref_impulse_x0", y[0], 354);
        check("ref_impulse_x1", y[1], 490);
        apply_stimulus(x, 1'b0, e_cyc);
        check_output(y, e_cyc, 1, 1'b0);

        $display("[TB] inverse DC block");
        for (int i = 0; i < N; i++) x[i] = 0;
        x[0] = 2828;
        y = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        apply_stimulus(x, 1'b1, e_cyc);
        check_output(y, e_cyc, 0, 1'b0);

        $display("[TB] full-scale forward block");
        for (int i = 0; i < N; i++) x[i] = 32767;
`ifdef DCT_SAT_EN
        y = '{32767, 0, 0, 0, 0, 0, 0, 0};
`else
        y = '{27141, 0, 0, 0, 0, 0, 0, 0};
`endif
        apply_stimulus(x, 1'b0, e_cyc);
        check_output(y, e_cyc, 0, 1'b0);

        $display("[TB] reset during MAC");
        for (int i = 0; i < N; i++) x[i] = int'($urandom_range(0, 2000)) - 1000;
        apply_stimulus(x, 1'b0, e_cyc);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", bus.in_ready, 1);
        check("postrst_busy", bus.busy, 0);
        check("postrst_out_valid", bus.out_valid, 0);
        ref_dct(x, 1'b0, y);
        apply_stimulus(x, 1'b0, e_cyc);
        check_output(y, e_cyc, 0, 1'b0);

        $display("[TB] random blocks");
        for (int b = 0; b < 8; b++) begin
            amp  = (b % 3 == 0) ? 32767 : ((b % 3 == 1) ? 4000 : 300);
            for (int i = 0; i < N; i++) x[i] = int'($urandom_range(0, 2 * amp)) - amp;
            mode = 1'($urandom_range(0, 1));
            ref_dct(x, mode, y);
            apply_stimulus(x, mode, e_cyc);
            check_output(y, e_cyc, 2, 1'(b % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
